// File: rtl/vga_px_arbiter.sv
`default_nettype none
// vga_px_arbiter: shares the VGA pixel-buffer Avalon-MM write master between the
// game pixel writer (s0) and the background fill engine (s1), one latched word per grant.
// Revision: 1.0
module vga_px_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] s0_address,
  input  logic [15:0] s0_writedata,
  input  logic        s0_write,
  output logic        s0_waitrequest,
  input  logic [31:0] s1_address,
  input  logic [15:0] s1_writedata,
  input  logic        s1_write,
  output logic        s1_waitrequest,
  output logic [31:0] vga_px_address,
  output logic [15:0] vga_px_writedata,
  output logic        vga_px_write,
  input  logic        vga_px_waitrequest,
  output logic [1:0]  grant_export,
  output logic        busy
);

  // State codes double as the one-hot grant vector.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT0 = 2'b01;
  localparam logic [1:0] ST_GRANT1 = 2'b10;
  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [15:0] r_data;
  logic        r_write;
  logic        r_last_grant;
  logic [7:0]  r_wait_cnt;
  logic        w_gnt0;
  logic        w_gnt1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == ST_IDLE) begin
      if (s0_write && s1_write) begin
        if (FIXED_PRIO == 0) begin
          w_gnt0 = r_last_grant;
          w_gnt1 = !r_last_grant;
        end else if (r_wait_cnt >= c_max_wait) begin
          w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = 1'b1;
        end
      end else begin
        w_gnt0 = s0_write;
        w_gnt1 = s1_write;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_write      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_addr       <= w_gnt1 ? s1_address : s0_address;
            r_data       <= w_gnt1 ? s1_writedata : s0_writedata;
            r_write      <= 1'b1;
            r_last_grant <= w_gnt1;
            r_state      <= w_gnt1 ? ST_GRANT1 : ST_GRANT0;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (r_write && !vga_px_waitrequest) begin
            r_write <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_write <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      // Counts how often s1 was passed over while it was asking.
      if (w_gnt1) begin
        r_wait_cnt <= '0;
      end else if (w_gnt0 && s1_write && (r_wait_cnt != 8'hFF)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  // The ack is gated by the requester's own write so an abandoned request never sees it.
  assign s0_waitrequest   = !(reset_n && (r_state == ST_GRANT0) && !vga_px_waitrequest && s0_write);
  assign s1_waitrequest   = !(reset_n && (r_state == ST_GRANT1) && !vga_px_waitrequest && s1_write);
  assign vga_px_address   = r_addr;
  assign vga_px_writedata = r_data;
  assign vga_px_write     = r_write;
  assign grant_export     = r_state;
  assign busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/vga_px_arbiter.md
Name: vga_px_arbiter

Overview:
- Shares the single VGA pixel-buffer Avalon-MM write master between two requesters.
- Requester 0 is the game pixel writer (snake, apple and power-up cells). Requester 1 is the background/clear-screen fill engine.
- Each requester sees an Avalon-MM slave write port with waitrequest. The arbiter latches one word per grant and drives it to the pixel buffer.
- Sits between the game FSM / fill engine and the vga_px master conduit of the snake top level.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 has priority, subject to MAX_WAIT.
- MAX_WAIT, 15, IDLE-state cycles requester 1 may be passed over in FIXED_PRIO mode before it is forced to win. Range 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s0_address  in  32  requester 0 pixel address (VGA_PX_BASE | y<<10 | x<<1)
- s0_writedata  in  16  requester 0 RGB565 pixel
- s0_write  in  1  requester 0 write request
- s0_waitrequest  out  1  requester 0 stall
- s1_address  in  32  requester 1 pixel address
- s1_writedata  in  16  requester 1 pixel
- s1_write  in  1  requester 1 write request
- s1_waitrequest  out  1  requester 1 stall
- vga_px_address  out  32  master address (registered)
- vga_px_writedata  out  16  master data (registered)
- vga_px_write  out  1  master write (registered)
- vga_px_waitrequest  in  1  pixel buffer stall
- grant_export  out  2  debug conduit: bit0 = requester 0 granted, bit1 = requester 1 granted
- busy  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state = IDLE, vga_px_write = 0, vga_px_address = 0, vga_px_writedata = 0, grant_export = 0, last_grant = 1 (so requester 0 wins the first round-robin tie), wait_cnt = 0.
- Waitrequest during reset: s0_waitrequest = s1_waitrequest = 1.
- State IDLE:
  - No s*_write high: stay in IDLE.
  - Exactly one s*_write high: grant that requester.
  - Both high, FIXED_PRIO = 0: grant the requester that is not last_grant.
  - Both high, FIXED_PRIO = 1: grant requester 1 if wait_cnt >= MAX_WAIT, else requester 0.
  - On any grant:
    - latch the winner's address and writedata into vga_px_address and vga_px_writedata;
    - set vga_px_write = 1;
    - set last_grant = winner;
    - move to GRANT0 or GRANT1.
- wait_cnt:
  - Increments, saturating at 255, on each IDLE cycle where s1_write = 1 and requester 0 is granted.
  - Clears to 0 when requester 1 is granted.
  - Holds otherwise.
- States GRANT0 / GRANT1:
  - Hold vga_px_address, vga_px_writedata and vga_px_write stable while vga_px_waitrequest = 1.
  - The transfer completes on the cycle where vga_px_write = 1 and vga_px_waitrequest = 0. On that edge: vga_px_write goes to 0 and state goes to IDLE.
- Requester waitrequest (combinational):
  - s_i_waitrequest = 0 only in GRANTi when vga_px_waitrequest = 0; 1 in every other case.
  - The requester therefore sees exactly one low-waitrequest cycle per accepted write.
- Latency:
  - Request high in IDLE at cycle N → vga_px_write = 1 at N+1.
  - With no pixel-buffer stall, the requester's waitrequest is low at N+1 and the arbiter is back in IDLE at N+2.
  - Peak throughput is 1 word per 2 cycles.
- Non-granted requester: its waitrequest stays 1 for the whole grant and its request is held. It is arbitrated in the next IDLE cycle.
- Simultaneous events:
  - A new request arriving in the completion cycle is not seen until IDLE.
  - Both requests arriving together are resolved only by the IDLE rule above.
- Protocol violation (requester drops write before its waitrequest falls):
  - The latched transfer still completes on the master.
  - The completion is not reflected to that requester, because its waitrequest is gated by s_i_write.
- Reset mid-transfer: vga_px_write drops asynchronously and the latched word is discarded. Requesters must reissue after reset.
- Outputs: grant_export = one-hot of the GRANT state, 0 in IDLE. busy = (state != IDLE).

Test Plan:
- Single write, no stall: s0 writes addr 0x0800_0000 | (5<<10) | (7<<1), data 0x07E0. Required response: vga_px_write = 1 with that address and data one cycle later; s0_waitrequest low for exactly 1 cycle; busy for 1 cycle.
- Stall: as above with vga_px_waitrequest held high 4 cycles. Required response: master address, data and write stable for 5 cycles; s0_waitrequest low only in the 5th; then IDLE.
- Round-robin (FIXED_PRIO = 0): both requesters hold write continuously for 8 transfers. Required response: grant order 0,1,0,1,0,1,0,1; each requester receives exactly 4 low-waitrequest pulses.
- Starvation (FIXED_PRIO = 1, MAX_WAIT = 3): s0 and s1 both requesting continuously. Required response: grants 0,0,0,1,0,0,0,1.
- Reset mid-transfer: assert reset_n = 0 while in GRANT1 with vga_px_waitrequest = 1. Required response: vga_px_write = 0 and grant_export = 0 immediately without a clock edge; after release, first tie goes to requester 0.
- Early drop: s1 drops write while vga_px_waitrequest = 1. Required response: master still completes the write; s1_waitrequest never goes low; arbiter returns to IDLE.
